// File: rtl/power_meter_pkg.sv
// Shared types and default parameter values for the toggle power meter.
package power_meter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMeasure,
    StReport
  } state_e;

  localparam int unsigned DefWindow     = 256;
  localparam int unsigned DefCntW       = 16;
  localparam int unsigned DefAccW       = 24;
  localparam int unsigned DefEPerToggle = 5;

  // Cycles after reset release before a measurement may start.
  localparam int unsigned WarmupCycles  = 3;

endpackage

// File: rtl/toggle_power_meter_if.sv
// Control and report bundle between the power meter and its consumer.
interface toggle_power_meter_if
  import power_meter_pkg::*;
#(
  parameter int unsigned CNT_W = DefCntW,
  parameter int unsigned ACC_W = DefAccW
) ();

  logic             enable;
  logic             nota_in;
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_toggles;
  logic [ACC_W-1:0] rpt_energy;
  logic             rpt_overflow;
  logic             busy;

  // Consumer / stimulus side.
  modport master (
    output enable, nota_in, rpt_ready,
    input  rpt_valid, rpt_toggles, rpt_energy, rpt_overflow, busy
  );

  // Meter side.
  modport slave (
    input  enable, nota_in, rpt_ready,
    output rpt_valid, rpt_toggles, rpt_energy, rpt_overflow, busy
  );

endinterface

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer followed by a registered any-edge detector.
// A level change sampled at edge k shows up as a one-cycle pulse after edge k+2.
module sync_edge_detect (
  input  logic clk,
  input  logic reset_L,
  input  logic d_async,
  output logic toggle
);

  logic sync1_q, sync2_q, prev_q, toggle_q;

  // Synchronize, remember previous level, and register the difference.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      prev_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      sync1_q  <= d_async;
      sync2_q  <= sync1_q;
      prev_q   <= sync2_q;
      toggle_q <= sync2_q ^ prev_q;
    end
  end

  assign toggle = toggle_q;

endmodule

// File: rtl/toggle_power_meter.sv
// Windowed toggle counter and switching-energy estimator for an observed
// inverter output, reporting each window through a valid/ready handshake.
module toggle_power_meter
  import power_meter_pkg::*;
#(
  parameter int unsigned WINDOW       = DefWindow,
  parameter int unsigned CNT_W        = DefCntW,
  parameter int unsigned ACC_W        = DefAccW,
  parameter int unsigned E_PER_TOGGLE = DefEPerToggle
) (
  input  logic clk,
  input  logic reset_L,
  toggle_power_meter_if.slave bus
);

  localparam int unsigned   WinW     = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam logic [WinW-1:0] WinLast = WinW'(WINDOW - 1);
  localparam logic [ACC_W:0]  EInc    = (ACC_W + 1)'(E_PER_TOGGLE);
  localparam logic [1:0]      WarmDone = 2'(WarmupCycles);

  state_e           state_q, state_d;
  logic [1:0]       warm_q, warm_d;
  logic [WinW-1:0]  win_q, win_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic [ACC_W-1:0] nrg_q, nrg_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] rpt_tog_q, rpt_tog_d;
  logic [ACC_W-1:0] rpt_nrg_q, rpt_nrg_d;
  logic             rpt_ovf_q, rpt_ovf_d;

  logic             toggle;
  logic [CNT_W:0]   tog_sum;
  logic [ACC_W:0]   nrg_sum;
  logic [CNT_W-1:0] tog_next;
  logic [ACC_W-1:0] nrg_next;
  logic             ovf_next;
  logic             start_win;
  logic             warm_done;

  // Edge detection runs in every state so entering MEASURE sees no stale edge.
  sync_edge_detect u_sync_edge_detect (
    .clk     (clk),
    .reset_L (reset_L),
    .d_async (bus.nota_in),
    .toggle  (toggle)
  );

  // Saturating accumulation of this cycle's toggle.
  always_comb begin
    tog_sum  = {1'b0, tog_q} + {{CNT_W{1'b0}}, 1'b1};
    nrg_sum  = {1'b0, nrg_q} + EInc;
    tog_next = tog_q;
    nrg_next = nrg_q;
    ovf_next = ovf_q;
    if (toggle) begin
      tog_next = tog_sum[CNT_W] ? '1 : tog_sum[CNT_W-1:0];
      nrg_next = nrg_sum[ACC_W] ? '1 : nrg_sum[ACC_W-1:0];
      ovf_next = ovf_q | tog_sum[CNT_W] | nrg_sum[ACC_W];
    end
  end

  assign warm_done = (warm_q == WarmDone);

  // Next-state logic for the measure/report sequencer.
  always_comb begin
    state_d   = state_q;
    warm_d    = warm_done ? warm_q : warm_q + 2'd1;
    win_d     = win_q;
    tog_d     = tog_q;
    nrg_d     = nrg_q;
    ovf_d     = ovf_q;
    rpt_tog_d = rpt_tog_q;
    rpt_nrg_d = rpt_nrg_q;
    rpt_ovf_d = rpt_ovf_q;
    start_win = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.enable && warm_done) begin
          state_d   = StMeasure;
          start_win = 1'b1;
        end
      end
      StMeasure: begin
        if (!bus.enable) begin
          state_d = StIdle;
        end else begin
          tog_d = tog_next;
          nrg_d = nrg_next;
          ovf_d = ovf_next;
          if (win_q == WinLast) begin
            rpt_tog_d = tog_next;
            rpt_nrg_d = nrg_next;
            rpt_ovf_d = ovf_next;
            state_d   = StReport;
          end else begin
            win_d = win_q + 1'b1;
          end
        end
      end
      StReport: begin
        if (bus.rpt_ready) begin
          if (bus.enable) begin
            state_d   = StMeasure;
            start_win = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_win) begin
      win_d = '0;
      tog_d = '0;
      nrg_d = '0;
      ovf_d = 1'b0;
    end
  end

  // State and datapath registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q   <= StIdle;
      warm_q    <= 2'd0;
      win_q     <= '0;
      tog_q     <= '0;
      nrg_q     <= '0;
      ovf_q     <= 1'b0;
      rpt_tog_q <= '0;
      rpt_nrg_q <= '0;
      rpt_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      warm_q    <= warm_d;
      win_q     <= win_d;
      tog_q     <= tog_d;
      nrg_q     <= nrg_d;
      ovf_q     <= ovf_d;
      rpt_tog_q <= rpt_tog_d;
      rpt_nrg_q <= rpt_nrg_d;
      rpt_ovf_q <= rpt_ovf_d;
    end
  end

  assign bus.rpt_valid    = (state_q == StReport);
  assign bus.busy         = (state_q != StIdle);
  assign bus.rpt_toggles  = rpt_tog_q;
  assign bus.rpt_energy   = rpt_nrg_q;
  assign bus.rpt_overflow = rpt_ovf_q;

endmodule
